fpu_issue_ctrl: RTL and testbench

Initiator-side sequencer that drives the floating-point unit's start/finish handshake on behalf of the core pipeline. It accepts one FP add/multiply request through a valid/ready port and latches the operands. It then sequences the FPU's operand, op-select and start lines, waits for finish, and captures the result. The result and destination register are returned to writeback through a valid/ready response port. It sits between the execute stage and the FPU, one operation in flight at a time.

---
 rtl/fpu_issue_ctrl_if.sv | 32 +++
 rtl/fpu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - request, FPU and response handshake bundle for fpu_issue_ctrl
interface fpu_issue_ctrl_if #(
    parameter int RD_W = 5
);
    logic            req_valid;
    logic            req_ready;
    logic            req_mul;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [RD_W-1:0] req_rd;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_mul;
    logic            fpu_start;
    logic            fpu_finish;
    logic [31:0]     fpu_s;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [RD_W-1:0] resp_rd;
    logic            resp_err;

    modport master (
        input  req_valid, req_mul, req_a, req_b, req_rd, fpu_finish, fpu_s, resp_ready,
        output req_ready, fpu_a, fpu_b, fpu_mul, fpu_start, resp_valid, resp_data, resp_rd, resp_err
    );

    modport slave (
        output req_valid, req_mul, req_a, req_b, req_rd, fpu_finish, fpu_s, resp_ready,
        input  req_ready, fpu_a, fpu_b, fpu_mul, fpu_start, resp_valid, resp_data, resp_rd, resp_err
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - single-op FPU start/finish sequencer; FPU_ISSUE_TIMEOUT_EN adds a RUN abort timer
module fpu_issue_ctrl #(
`ifdef FPU_ISSUE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 4096,
`endif
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    fpu_issue_ctrl_if.master bus,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_done_o
);
    typedef enum logic [2:0] {IDLE, SETUP, RUN, RESP, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d, b_q, b_d, data_q, data_d;
    logic            mul_q, mul_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic            start_q, valid_q, ready_q, busy_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mul_d   = mul_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ops_d   = ops_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
        tmr_d   = tmr_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (bus.req_valid) begin
                a_d     = bus.req_a;
                b_d     = bus.req_b;
                mul_d   = bus.req_mul;
                rd_d    = bus.req_rd;
                state_d = SETUP;
            end
            SETUP: begin
`ifdef FPU_ISSUE_TIMEOUT_EN
                tmr_d   = '0;
`endif
                state_d = RUN;
            end
            RUN: if (bus.fpu_finish) begin
                data_d  = bus.fpu_s;
`ifdef FPU_ISSUE_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = RESP;
            end
`ifdef FPU_ISSUE_TIMEOUT_EN
            // Abort on the TIMEOUT_CYCLES-th RUN cycle with a quiet NaN result.
            else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                data_d  = 32'h7FC0_0000;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                tmr_d   = tmr_q + TW'(1);
            end
`endif
            RESP: if (bus.resp_ready) begin
                ops_d   = ops_q + CNT_W'(1);
                state_d = bus.fpu_finish ? DRAIN : IDLE;
            end
            DRAIN: if (!bus.fpu_finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            ops_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ops_q   <= ops_d;
            start_q <= (state_d == RUN);
            valid_q <= (state_d == RESP);
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
`ifdef FPU_ISSUE_TIMEOUT_EN
            tmr_q   <= tmr_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.fpu_a      = a_q;
    assign bus.fpu_b      = b_q;
    assign bus.fpu_mul    = mul_q;
    assign bus.fpu_start  = start_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_data  = data_q;
    assign bus.resp_rd    = rd_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    assign bus.resp_err   = err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
    assign busy_o         = busy_q;
    assign ops_done_o     = ops_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] ops_done;
    int          total = 0;
    int          bad   = 0;

    fpu_issue_ctrl_if #(.RD_W(5)) bus ();

    fpu_issue_ctrl #(
`ifdef FPU_ISSUE_TIMEOUT_EN
        .TIMEOUT_CYCLES(8),
`endif
        .RD_W(5),
        .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy_o     (busy),
        .ops_done_o (ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic mul, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_mul   = mul;
        bus.req_rd    = rd;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_mul    = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_rd     = '0;
        bus.fpu_finish = 1'b0;
        bus.fpu_s      = '0;
        bus.resp_ready = 1'b0;

        #1;
        chk("rst_start", bus.fpu_start, 0);
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_err", bus.resp_err, 0);
        chk("rst_data", bus.resp_data, 0);
        chk("rst_fpu_a", bus.fpu_a, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 1);
        #11 rst = 1'b0;
        tick();

        // add 2.5 + 3.0, FPU finishes 10 cycles after start
        drive_req(32'h4020_0000, 32'h4040_0000, 1'b0, 5'd5);
        tick();
        bus.req_valid = 1'b0;
        chk("add_setup_busy", busy, 1);
        chk("add_setup_ready", bus.req_ready, 0);
        chk("add_setup_start", bus.fpu_start, 0);
        chk("add_fpu_a", bus.fpu_a, 32'h4020_0000);
        chk("add_fpu_b", bus.fpu_b, 32'h4040_0000);
        chk("add_fpu_mul", bus.fpu_mul, 0);
        tick();
        chk("add_start_edge1", bus.fpu_start, 1);
        chk("add_valid_run", bus.resp_valid, 0);
        repeat (9) tick();
        chk("add_start_held", bus.fpu_start, 1);
        bus.fpu_finish = 1'b1;
        bus.fpu_s      = 32'h40B0_0000;
        tick();
        chk("add_valid", bus.resp_valid, 1);
        chk("add_data", bus.resp_data, 32'h40B0_0000);
        chk("add_rd", bus.resp_rd, 5);
        chk("add_err", bus.resp_err, 0);
        chk("add_start_resp", bus.fpu_start, 0);
        chk("add_ready_resp", bus.req_ready, 0);
        bus.fpu_finish = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("add_valid_drop", bus.resp_valid, 0);
        chk("add_ops", ops_done, 1);
        chk("add_idle_ready", bus.req_ready, 1);
        bus.resp_ready = 1'b0;

        // stray finish in IDLE
        bus.fpu_finish = 1'b1;
        repeat (2) tick();
        chk("idle_fin_busy", busy, 0);
        chk("idle_fin_valid", bus.resp_valid, 0);
        chk("idle_fin_start", bus.fpu_start, 0);
        bus.fpu_finish = 1'b0;

        // multiply 2.5 * 3.0
        drive_req(32'h4020_0000, 32'h4040_0000, 1'b1, 5'd7);
        tick();
        bus.req_valid = 1'b0;
        chk("mul_setup_mul", bus.fpu_mul, 1);
        tick();
        chk("mul_run_start", bus.fpu_start, 1);
        chk("mul_run_mul", bus.fpu_mul, 1);
        repeat (2) tick();
        bus.fpu_finish = 1'b1;
        bus.fpu_s      = 32'h40F0_0000;
        tick();
        chk("mul_valid", bus.resp_valid, 1);
        chk("mul_data", bus.resp_data, 32'h40F0_0000);
        chk("mul_rd", bus.resp_rd, 7);
        chk("mul_resp_mul", bus.fpu_mul, 1);
        bus.fpu_finish = 1'b0;

        // 20 cycles of backpressure with a second request waiting
        drive_req(32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd9);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_data", bus.resp_data, 32'h40F0_0000);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_start", bus.fpu_start, 0);
            chk("bp_fpu_a", bus.fpu_a, 32'h4020_0000);
            chk("bp_mul", bus.fpu_mul, 1);
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", bus.resp_valid, 0);
        chk("bp_hs_ops", ops_done, 2);
        chk("bp_hs_ready", bus.req_ready, 1);
        bus.resp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("bp2_busy", busy, 1);
        chk("bp2_fpu_a", bus.fpu_a, 32'h3F80_0000);
        chk("bp2_rd", bus.resp_rd, 9);
        chk("bp2_mul", bus.fpu_mul, 0);

        // finish held high past the handshake: three DRAIN cycles
        tick();
        chk("dr_start", bus.fpu_start, 1);
        bus.fpu_finish = 1'b1;
        bus.fpu_s      = 32'h4000_0000;
        tick();
        chk("dr_data", bus.resp_data, 32'h4000_0000);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk("dr_valid", bus.resp_valid, 0);
        chk("dr_ops", ops_done, 3);
        chk("dr_busy0", busy, 1);
        chk("dr_ready0", bus.req_ready, 0);
        drive_req(32'h4100_0000, 32'h4100_0000, 1'b1, 5'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("dr_busy", busy, 1);
            chk("dr_ready", bus.req_ready, 0);
            chk("dr_fpu_a", bus.fpu_a, 32'h3F80_0000);
        end
        bus.fpu_finish = 1'b0;
        tick();
        chk("dr_exit_ready", bus.req_ready, 1);
        chk("dr_exit_busy", busy, 0);
        tick();
        bus.req_valid = 1'b0;
        chk("dr_new_fpu_a", bus.fpu_a, 32'h4100_0000);
        chk("dr_new_rd", bus.resp_rd, 2);

        // asynchronous reset in RUN
        tick();
        tick();
        chk("ar_start_pre", bus.fpu_start, 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_start", bus.fpu_start, 0);
        chk("ar_valid", bus.resp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ops", ops_done, 0);
        chk("ar_fpu_a", bus.fpu_a, 0);
        #2 rst = 1'b0;
        tick();
        drive_req(32'h4020_0000, 32'h4040_0000, 1'b0, 5'd3);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("post_start", bus.fpu_start, 1);
        bus.fpu_finish = 1'b1;
        bus.fpu_s      = 32'h40B0_0000;
        tick();
        chk("post_valid", bus.resp_valid, 1);
        chk("post_data", bus.resp_data, 32'h40B0_0000);
        chk("post_rd", bus.resp_rd, 3);
        chk("post_err", bus.resp_err, 0);
        bus.fpu_finish = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("post_ops", ops_done, 1);
        chk("post_valid_drop", bus.resp_valid, 0);
        bus.resp_ready = 1'b0;

`ifdef FPU_ISSUE_TIMEOUT_EN
        // FPU never finishes; abort after 8 RUN cycles
        drive_req(32'h4020_0000, 32'h4040_0000, 1'b1, 5'd4);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("to_start", bus.fpu_start, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_valid", bus.resp_valid, 0);
            chk("to_wait_start", bus.fpu_start, 1);
        end
        tick();
        chk("to_valid", bus.resp_valid, 1);
        chk("to_data", bus.resp_data, 32'h7FC0_0000);
        chk("to_err", bus.resp_err, 1);
        chk("to_start_drop", bus.fpu_start, 0);
        chk("to_rd", bus.resp_rd, 4);
        bus.resp_ready = 1'b1;
        tick();
        chk("to_ops", ops_done, 2);
        chk("to_valid_drop", bus.resp_valid, 0);
        bus.resp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
